// File: rtl/waterfall_pkg.sv
// rtl/waterfall_pkg.sv - shared widths, defaults and FSM encoding for the waterfall row writer
package waterfall_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_BINS  = 64;
    localparam int DEF_ROWS  = 32;
    localparam int DEF_PIX_W = 8;
    localparam int BINS_W    = $clog2(DEF_BINS);
    localparam int ROWS_W    = $clog2(DEF_ROWS);

    typedef enum logic {
        ST_ACCEPT  = 1'b0,
        ST_ADVANCE = 1'b1
    } state_t;

endpackage

// File: rtl/mag_compress.sv
// rtl/mag_compress.sv - combinational magnitude-to-pixel compressor
// Linear saturating map by default; WATERFALL_LOG_SCALE_EN selects the log2 approximation.
module mag_compress #(
    parameter int WIDTH      = 16,
    parameter int PIX_W      = 8,
    parameter int GAIN_SHIFT = 4
) (
    input  logic [WIDTH-1:0] i_mag,
    output logic [PIX_W-1:0] o_pix
);

`ifdef WATERFALL_LOG_SCALE_EN
    localparam int PW = $clog2(WIDTH);
    localparam int HW = PIX_W / 2;

    logic [PW-1:0]    w_p;
    logic [WIDTH-1:0] w_norm;
    logic [HW-1:0]    w_exp;
    logic [HW-1:0]    w_frac;

    always_comb begin
        w_p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_mag[i]) begin
                w_p = PW'(i);
            end
        end
    end

    // Left-justify so the bits under the MSB line up; short mantissas pad with zeros.
    assign w_norm = i_mag << (WIDTH - 1 - int'(w_p));
    assign w_frac = w_norm[WIDTH-2 -: HW];
    assign w_exp  = HW'(w_p);
    assign o_pix  = {w_exp, w_frac};
`else
    localparam logic [WIDTH-1:0] PIX_MAX = WIDTH'((1 << PIX_W) - 1);

    logic [WIDTH-1:0] w_shifted;

    assign w_shifted = i_mag >> GAIN_SHIFT;
    assign o_pix     = (w_shifted > PIX_MAX) ? {PIX_W{1'b1}} : w_shifted[PIX_W-1:0];
`endif

endmodule

// File: rtl/waterfall_row_writer.sv
// rtl/waterfall_row_writer.sv - writes compressed FFT magnitudes into a ring of frame-buffer rows
// Build option: WATERFALL_LOG_SCALE_EN (log2 pixel mapping inside mag_compress).
module waterfall_row_writer
    import waterfall_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int BINS       = DEF_BINS,
    parameter int ROWS       = DEF_ROWS,
    parameter int PIX_W      = DEF_PIX_W,
    parameter int GAIN_SHIFT = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [WIDTH-1:0]                     mag,
    input  logic                                 mag_valid,
    input  logic                                 mag_first,
    output logic                                 mag_ready,
    output logic [$clog2(ROWS)+$clog2(BINS)-1:0] fb_addr,
    output logic [PIX_W-1:0]                     fb_data,
    output logic                                 fb_we,
    output logic [$clog2(ROWS)-1:0]              top_row,
    output logic                                 line_done,
    output logic                                 resync_err
);

    localparam int BW = $clog2(BINS);
    localparam int RW = $clog2(ROWS);

    state_t           r_state;
    logic [BW-1:0]    r_bin_cnt;
    logic [RW-1:0]    r_row_ptr;
    logic [RW-1:0]    r_top_row;
    logic [RW+BW-1:0] r_fb_addr;
    logic [PIX_W-1:0] r_fb_data;
    logic             r_fb_we;
    logic             r_line_done;
    logic             r_resync_err;
    logic             r_mag_ready;

    logic             w_accept;
    logic             w_resync;
    logic             w_last;
    logic [PIX_W-1:0] w_pix;

    mag_compress #(
        .WIDTH      (WIDTH),
        .PIX_W      (PIX_W),
        .GAIN_SHIFT (GAIN_SHIFT)
    ) u_mag_compress (
        .i_mag (mag),
        .o_pix (w_pix)
    );

    assign w_accept = mag_valid && r_mag_ready;
    assign w_resync = w_accept && mag_first && (r_bin_cnt != '0);
    assign w_last   = w_accept && !w_resync && (r_bin_cnt == BW'(BINS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_ACCEPT;
            r_bin_cnt    <= '0;
            r_row_ptr    <= '0;
            r_top_row    <= '0;
            r_fb_addr    <= '0;
            r_fb_data    <= '0;
            r_fb_we      <= 1'b0;
            r_line_done  <= 1'b0;
            r_resync_err <= 1'b0;
            r_mag_ready  <= 1'b1;
        end else begin
            r_fb_we      <= 1'b0;
            r_line_done  <= 1'b0;
            r_resync_err <= 1'b0;
            case (r_state)
                ST_ACCEPT: begin
                    if (w_accept) begin
                        r_fb_we   <= 1'b1;
                        r_fb_data <= w_pix;
                        if (w_resync) begin
                            // Restart the current row in place; the ring does not advance.
                            r_fb_addr    <= {r_row_ptr, {BW{1'b0}}};
                            r_bin_cnt    <= BW'(1);
                            r_resync_err <= 1'b1;
                        end else begin
                            r_fb_addr <= {r_row_ptr, r_bin_cnt};
                            r_bin_cnt <= r_bin_cnt + BW'(1);
                        end
                        // Row completion is flagged alongside the final write of the row.
                        if (w_last) begin
                            r_top_row   <= r_row_ptr;
                            r_line_done <= 1'b1;
                            r_mag_ready <= 1'b0;
                            r_state     <= ST_ADVANCE;
                        end
                    end
                end
                ST_ADVANCE: begin
                    r_row_ptr   <= r_row_ptr + RW'(1);
                    r_mag_ready <= 1'b1;
                    r_state     <= ST_ACCEPT;
                end
                default: begin
                    r_state     <= ST_ACCEPT;
                    r_mag_ready <= 1'b1;
                end
            endcase
        end
    end

    assign mag_ready  = r_mag_ready;
    assign fb_addr    = r_fb_addr;
    assign fb_data    = r_fb_data;
    assign fb_we      = r_fb_we;
    assign top_row    = r_top_row;
    assign line_done  = r_line_done;
    assign resync_err = r_resync_err;

endmodule
